im_fetch_unit: RTL and testbench

// - Read-side client of the instruction memory. Drives the 6-bit word-pair select and takes the 64-bit pair it returns.
// - Extracts one 32-bit slot per fetch, drops all-zero padding slots, tags compressed (RVC) encodings, and presents instructions to decode on a valid/ready handshake.
// - Handles PC redirect (branch/jump) and halts after a run of empty slots.

---
 rtl/ifetch_pkg.sv | 15 +
 rtl/im_fetch_unit.sv | 97 +++++++++
 tb/tb_im_fetch_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-memory fetch path.
package ifetch_pkg;

  localparam int unsigned IM_WORDS   = 64;
  localparam int unsigned IM_SEL_W   = 6;
  localparam int unsigned ZERO_CNT_W = 4;

  localparam logic [1:0] RVC_QUAD_FULL = 2'b11;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/im_fetch_unit.sv
// Instruction-memory read client: walks the PC, skips zero padding slots,
// tags RVC encodings and hands instructions to decode on valid/ready.
module im_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 8,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int unsigned       MAX_ZERO_RUN = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic [IM_SEL_W-1:0] im_sel,
  input  logic [63:0]         im_data,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [31:0]         instr,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic                instr_is_c,
  output logic                halted
);

  localparam logic [ADDR_W-1:0]     PC_MASK   = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0]     PC_STEP   = ADDR_W'(4);
  localparam logic [ZERO_CNT_W-1:0] ZERO_HALT = ZERO_CNT_W'(MAX_ZERO_RUN);

  fetch_state_t            state_q, state_d;
  logic [ADDR_W-1:0]       pc_q, pc_d;
  logic [ZERO_CNT_W-1:0]   zero_cnt_q, zero_cnt_d;
  logic                    valid_d;
  logic                    load_out;
  logic                    out_free;
  logic [31:0]             word;
  logic                    slot_is_c;
  logic [31:0]             slot_instr;

  // Even slot sits in the upper half of the pair.
  assign word       = pc_q[2] ? im_data[31:0] : im_data[63:32];
  assign slot_is_c  = (word[1:0] != RVC_QUAD_FULL);
  assign slot_instr = slot_is_c ? {16'b0, word[15:0]} : word;

  assign out_free = !instr_valid || instr_ready;
  assign im_sel   = pc_q[IM_SEL_W+1:2];
  assign halted   = (state_q == HALT);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    zero_cnt_d = zero_cnt_q;
    valid_d    = instr_valid;
    load_out   = 1'b0;
    if (redirect_valid) begin
      // Flush wins over any fetch; a concurrent handshake still completes.
      state_d    = RUN;
      pc_d       = redirect_pc & PC_MASK;
      zero_cnt_d = '0;
      valid_d    = 1'b0;
    end else if (state_q == RUN && out_free) begin
      pc_d = pc_q + PC_STEP;
      if (word != '0) begin
        load_out   = 1'b1;
        valid_d    = 1'b1;
        zero_cnt_d = '0;
      end else begin
        valid_d    = 1'b0;
        zero_cnt_d = zero_cnt_q + 1'b1;
        if (zero_cnt_d == ZERO_HALT) begin
          state_d = HALT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC & PC_MASK;
      zero_cnt_q  <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_is_c  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      zero_cnt_q  <= zero_cnt_d;
      instr_valid <= valid_d;
      if (load_out) begin
        instr      <= slot_instr;
        instr_pc   <= pc_q;
        instr_is_c <= slot_is_c;
      end
    end
  end

endmodule

// File: tb/tb_im_fetch_unit.sv
// Directed bench for im_fetch_unit: per-cycle vector table plus hand-written
// halt, wrap, redirect-with-handshake and asynchronous reset sequences.
module tb_im_fetch_unit;

  typedef struct {
    logic        rv;
    logic [7:0]  rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] ei;
    logic [7:0]  epc;
    logic        ec;
    logic [5:0]  esel;
    logic        eh;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  im_sel;
  logic [63:0] im_data;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_is_c;
  logic        halted;

  logic [31:0] mem [64];
  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  assign im_data = {mem[{im_sel[5:1], 1'b0}], mem[{im_sel[5:1], 1'b1}]};

  im_fetch_unit #(
    .ADDR_W(8),
    .RESET_PC(8'h00),
    .MAX_ZERO_RUN(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .im_sel(im_sel),
    .im_data(im_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_is_c(instr_is_c),
    .halted(halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_instr(input string tag, input logic [31:0] ei, input logic [7:0] epc,
                           input logic ec, input logic [5:0] esel);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
    chk({tag, ".instr"}, instr, ei);
    chk({tag, ".pc"}, 32'(instr_pc), 32'(epc));
    chk({tag, ".is_c"}, 32'(instr_is_c), 32'(ec));
    chk({tag, ".sel"}, 32'(im_sel), 32'(esel));
  endtask

  task automatic chk_idle(input string tag, input logic [5:0] esel, input logic eh);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
    chk({tag, ".sel"}, 32'(im_sel), 32'(esel));
    chk({tag, ".halted"}, 32'(halted), 32'(eh));
  endtask

  initial begin
    logic [7:0] exp_pc;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[1]  = 32'h0000_40F9;
    mem[2]  = 32'h0010_0093;
    mem[3]  = 32'h0000_4581;
    mem[6]  = 32'h0020_8133;
    mem[7]  = 32'h0000_8082;
    mem[8]  = 32'h0030_0193;
    mem[9]  = 32'h0040_0213;
    mem[10] = 32'h0050_0293;
    mem[11] = 32'h0060_0313;
    mem[12] = 32'h41C0_D213;
    mem[14] = 32'h0070_0393;
    for (int i = 15; i < 26; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);

    //           rv  rpc    rdy ev  instr          pc     c     sel    h
    vq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,          8'h00, 1'b0, 6'd0,  1'b0});
    vq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,          8'h00, 1'b0, 6'd1,  1'b0});
    vq.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_40F9,  8'h04, 1'b1, 6'd2,  1'b0});
    for (int i = 0; i < 5; i++)
      vq.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 32'h0010_0093, 8'h08, 1'b0, 6'd3, 1'b0});
    vq.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 32'h0010_0093,  8'h08, 1'b0, 6'd3,  1'b0});
    vq.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_4581,  8'h0C, 1'b1, 6'd4,  1'b0});
    vq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,          8'h00, 1'b0, 6'd5,  1'b0});
    vq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,          8'h00, 1'b0, 6'd6,  1'b0});
    vq.push_back('{1'b1, 8'h33, 1'b1, 1'b1, 32'h0020_8133,  8'h18, 1'b0, 6'd7,  1'b0});
    vq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,          8'h00, 1'b0, 6'd12, 1'b0});
    vq.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 32'h41C0_D213,  8'h30, 1'b0, 6'd13, 1'b0});
    vq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,          8'h00, 1'b0, 6'd14, 1'b0});
    vq.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 32'h0070_0393,  8'h38, 1'b0, 6'd15, 1'b0});

    @(negedge clk);
    @(negedge clk);
    chk("rst.valid", 32'(instr_valid), 32'd0);
    chk("rst.instr", instr, 32'd0);
    chk("rst.pc", 32'(instr_pc), 32'd0);
    chk("rst.is_c", 32'(instr_is_c), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.sel", 32'(im_sel), 32'd0);
    reset = 1'b1;

    foreach (vq[k]) begin
      if (k > 0) @(negedge clk);
      redirect_valid = vq[k].rv;
      redirect_pc    = vq[k].rpc;
      instr_ready    = vq[k].rdy;
      if (vq[k].ev) chk_instr($sformatf("vec%0d", k), vq[k].ei, vq[k].epc, vq[k].ec, vq[k].esel);
      else          chk_idle($sformatf("vec%0d", k), vq[k].esel, vq[k].eh);
    end

    // Run into the zero tail: every slot 15..25 must be delivered in order.
    exp_pc = 8'h3C;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (halted) break;
      if (instr_valid && instr_ready) begin
        chk("run.pc", 32'(instr_pc), 32'(exp_pc));
        chk("run.instr", instr, mem[exp_pc[7:2]]);
        exp_pc = exp_pc + 8'd4;
      end
    end
    chk("halt.last_pc", 32'(exp_pc), 32'h68);
    for (int c = 0; c < 3; c++) begin
      chk_idle($sformatf("halt%0d", c), 6'd30, 1'b1);
      @(negedge clk);
    end

    redirect_valid = 1'b1;
    redirect_pc    = 8'h00;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk_idle("unhalt0", 6'd0, 1'b0);
    @(negedge clk);
    chk_idle("unhalt1", 6'd1, 1'b0);
    @(negedge clk);
    chk_instr("unhalt2", 32'h0000_40F9, 8'h04, 1'b1, 6'd2);

    // Handshake of slot1 and redirect to the last slot in the same cycle.
    mem[63]        = 32'h0000_0013;
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk_idle("wrap0", 6'd63, 1'b0);
    @(negedge clk);
    chk_instr("wrap1", 32'h0000_0013, 8'hFC, 1'b0, 6'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h04;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk_idle("hsredir0", 6'd1, 1'b0);
    @(negedge clk);
    chk_instr("hsredir1", 32'h0000_40F9, 8'h04, 1'b1, 6'd2);
    instr_ready = 1'b0;

    #2 reset = 1'b0;
    #1;
    chk("arst.valid", 32'(instr_valid), 32'd0);
    chk("arst.instr", instr, 32'd0);
    chk("arst.pc", 32'(instr_pc), 32'd0);
    chk("arst.is_c", 32'(instr_is_c), 32'd0);
    chk("arst.sel", 32'(im_sel), 32'd0);
    @(negedge clk);
    reset       = 1'b1;
    instr_ready = 1'b1;
    chk_idle("rstart0", 6'd0, 1'b0);
    @(negedge clk);
    chk_idle("rstart1", 6'd1, 1'b0);
    @(negedge clk);
    chk_instr("rstart2", 32'h0000_40F9, 8'h04, 1'b1, 6'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
